// File: rtl/feistel_pkg.sv
// ============================================================================
// Module      : feistel_pkg
// Description : Shared Feistel definitions (state enum, round function, key
//               schedule) used by both the encrypt and decrypt engines.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package feistel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } feistel_state_t;

  localparam int FEISTEL_ROT = 13;
  localparam int FEISTEL_SHR = 7;

  function automatic logic [63:0] feistel_f(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] s;
    s = x + k;
    return ((s << FEISTEL_ROT) | (s >> (64 - FEISTEL_ROT))) ^ (x >> FEISTEL_SHR);
  endfunction

  // Lane select is i mod 4; the round index is folded into the low bits.
  function automatic logic [63:0] feistel_round_key(input logic [255:0] mk, input logic [5:0] i);
    return mk[{i[1:0], 6'b0} +: 64] ^ {58'b0, i};
  endfunction

endpackage

`default_nettype wire

// File: rtl/feistel_decrypt_core_if.sv
// ============================================================================
// Module      : feistel_decrypt_core_if
// Description : Start/done job bus of the Feistel decrypt core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface feistel_decrypt_core_if;
  logic         start;
  logic [255:0] master_key;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         done;
  logic         busy;
  logic [5:0]   round_count;

  modport master (
    output start, master_key, data_in,
    input  data_out, done, busy, round_count
  );

  modport slave (
    input  start, master_key, data_in,
    output data_out, done, busy, round_count
  );
endinterface

`default_nettype wire

// File: rtl/feistel_round_unit.sv
// ============================================================================
// Module      : feistel_round_unit
// Description : One combinational Feistel round, forward or inverse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module feistel_round_unit
  import feistel_pkg::*;
(
  input  logic [63:0] l_in,
  input  logic [63:0] r_in,
  input  logic [63:0] k,
  input  logic        decrypt,
  output logic [63:0] l_out,
  output logic [63:0] r_out
);

  always_comb begin
    l_out = r_in;
    r_out = l_in ^ feistel_f(r_in, k);
    if (decrypt) begin
      l_out = r_in ^ feistel_f(l_in, k);
      r_out = l_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/feistel_decrypt_core.sv
// ============================================================================
// Module      : feistel_decrypt_core
// Description : Iterative Feistel decryptor, one round per cycle, start/done.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module feistel_decrypt_core
  import feistel_pkg::*;
#(
  parameter int ROUNDS = 48
) (
  input  logic                  clk,
  input  logic                  reset_n,
  feistel_decrypt_core_if.slave bus
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  feistel_state_t state_q, state_d;
  logic [63:0]    l_q, l_d, r_q, r_d;
  logic [255:0]   key_q, key_d;
  logic [5:0]     idx_q, idx_d;
  logic [127:0]   data_out_q, data_out_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [63:0]    round_key;
  logic [63:0]    l_next, r_next;

  assign round_key = feistel_round_key(key_q, idx_q);

  feistel_round_unit u_round (
    .l_in    (l_q),
    .r_in    (r_q),
    .k       (round_key),
    .decrypt (1'b1),
    .l_out   (l_next),
    .r_out   (r_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      l_q        <= '0;
      r_q        <= '0;
      key_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      r_q        <= r_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // busy stays high through the done cycle, which is already spent in IDLE.
  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    r_d        = r_q;
    key_d      = key_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = bus.start;
        if (bus.start) begin
          state_d = ST_ROUND;
          key_d   = bus.master_key;
          l_d     = bus.data_in[127:64];
          r_d     = bus.data_in[63:0];
          idx_d   = LAST_IDX;
        end
      end
      ST_ROUND: begin
        busy_d = 1'b1;
        l_d    = l_next;
        r_d    = r_next;
        if (idx_q == 6'd0) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 6'd1;
        end
      end
      ST_DONE: begin
        busy_d     = 1'b1;
        data_out_d = {l_q, r_q};
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.data_out    = data_out_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.round_count = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_feistel_decrypt_core.sv
// ============================================================================
// Module      : tb_feistel_decrypt_core
// Description : Directed-vector and round-trip bench for feistel_decrypt_core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_feistel_decrypt_core;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  feistel_decrypt_core_if if48 ();
  feistel_decrypt_core_if if1 ();

  feistel_decrypt_core #(.ROUNDS(48)) dut48 (.clk(clk), .reset_n(reset_n), .bus(if48));
  feistel_decrypt_core #(.ROUNDS(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(if1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    bit           sel;   // 1 = ROUNDS=1 instance, 0 = ROUNDS=48 instance
    logic [255:0] key;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Independent reference: rotate by explicit slicing, key lane by case.
  function automatic logic [63:0] m_f(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] s;
    s = x + k;
    return {s[50:0], s[63:51]} ^ {7'b0, x[63:7]};
  endfunction

  function automatic logic [63:0] m_key(input logic [255:0] mk, input int i);
    logic [63:0] lane;
    case (i % 4)
      0: lane = mk[63:0];
      1: lane = mk[127:64];
      2: lane = mk[191:128];
      default: lane = mk[255:192];
    endcase
    return lane ^ 64'(i);
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [255:0] mk, input logic [127:0] pt, input int rounds);
    logic [63:0] l, r, t;
    l = pt[127:64];
    r = pt[63:0];
    for (int i = 0; i < rounds; i++) begin
      t = r;
      r = l ^ m_f(r, m_key(mk, i));
      l = t;
    end
    return {l, r};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic s, input logic [255:0] k, input logic [127:0] d);
    if (sel) begin
      if1.start = s; if1.master_key = k; if1.data_in = d;
    end else begin
      if48.start = s; if48.master_key = k; if48.data_in = d;
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? if1.done : if48.done;
  endfunction

  function automatic logic [127:0] get_dout(input bit sel);
    return sel ? if1.data_out : if48.data_out;
  endfunction

  task automatic wait_done(input bit sel, input int max, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = -1;
    for (int c = 1; c <= max && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(sel)) begin
        cyc = c;
        seen = 1'b1;
      end
    end
  endtask

  // Returns at the negedge of the done cycle; lat counts edges after acceptance.
  task automatic run_job(input bit sel, input logic [255:0] k, input logic [127:0] d,
                         output logic [127:0] q, output int lat);
    @(negedge clk);
    set_in(sel, 1'b1, k, d);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, ~k, ~d);
    wait_done(sel, 200, lat);
    q = get_dout(sel);
  endtask

  localparam logic [255:0] SPEC_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] SPEC_PT = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    logic [127:0] q, pt_a, pt_b, ct_a, ct_b;
    logic [255:0] k;
    int lat, dones, done_at;

    vecs[0] = '{"r1_zero_f", 1'b1, 256'h0, {64'h0, 64'h1}, {64'h1, 64'h0}};
    vecs[1] = '{"r1_rot_l1", 1'b1, 256'h0, {64'h1, 64'h0}, {64'h2000, 64'h1}};
    vecs[2] = '{"r1_key_add", 1'b1, 256'h1, 128'h0, {64'h2000, 64'h0}};
    vecs[3] = '{"r1_shift", 1'b1, 256'h0, {64'h80, 64'h0}, {64'h100001, 64'h80}};
    vecs[4] = '{"r1_msb_wrap", 1'b1, 256'h0, {64'h8000000000000000, 64'h0},
                {64'h0100000000001000, 64'h8000000000000000}};
    vecs[5] = '{"r1_add_carry", 1'b1, 256'h1, {64'hFFFFFFFFFFFFFFFF, 64'h0},
                {64'h01FFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}};
    vecs[6] = '{"r1_lane0_only", 1'b1,
                {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h3333333333333333, 64'h0},
                {64'h0, 64'h1}, {64'h1, 64'h0}};
    vecs[7] = '{"r48_spec", 1'b0, SPEC_KEY, m_encrypt(SPEC_KEY, SPEC_PT, 48), SPEC_PT};
    vecs[8] = '{"r48_zero", 1'b0, 256'h0, m_encrypt(256'h0, 128'h0, 48), 128'h0};
    vecs[9] = '{"r48_ones", 1'b0, '1, m_encrypt('1, '1, 48), '1};

    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset_dout", if48.data_out, 128'h0);
    chk("reset_flags", {if48.done, if48.busy, if48.round_count}, 128'h0);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i].sel, vecs[i].key, vecs[i].din, q, lat);
      chk({vecs[i].name, "_data"}, q, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, 128'(lat), vecs[i].sel ? 128'd2 : 128'd49);
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, {127'h0, get_done(vecs[i].sel)}, 128'h0);
      chk({vecs[i].name, "_held"}, get_dout(vecs[i].sel), vecs[i].exp);
    end

    // Start while busy: second request must be dropped
    pt_a = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    pt_b = 128'h11111111_22222222_33333333_44444444;
    k    = {64'h0F0E0D0C0B0A0908, 64'h0706050403020100, 64'h1122334455667788, 64'h99AABBCCDDEEFF00};
    ct_a = m_encrypt(k, pt_a, 48);
    ct_b = m_encrypt(k, pt_b, 48);
    @(negedge clk);
    set_in(1'b0, 1'b1, k, ct_a);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, k, ct_a);
    chk("busy_after_accept", {126'h0, if48.busy}, 128'h1);
    chk("rc_first_round", 128'(if48.round_count), 128'd47);
    dones = 0;
    done_at = -1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 10) begin
        chk("rc_round_10", 128'(if48.round_count), 128'd37);
        set_in(1'b0, 1'b1, ~k, ct_b);
      end
      if (c == 11) set_in(1'b0, 1'b0, k, ct_a);
      if (if48.done) begin
        dones++;
        done_at = c;
        chk("busy_in_done_cycle", {127'h0, if48.busy}, 128'h1);
      end
      if (c == 50) chk("idle_flags", {if48.busy, if48.round_count}, 128'h0);
    end
    chk("ignored_start_dones", 128'(dones), 128'd1);
    chk("ignored_start_latency", 128'(done_at), 128'd49);
    chk("ignored_start_data", if48.data_out, pt_a);

    // Reset in the middle of a job
    @(negedge clk);
    set_in(1'b0, 1'b1, k, ct_b);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, k, ct_b);
    repeat (27) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rc_before_reset", 128'(if48.round_count), 128'd20);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_dout", if48.data_out, 128'h0);
    chk("midreset_flags", {if48.done, if48.busy, if48.round_count}, 128'h0);
    chk("midreset_dout_r1", if1.data_out, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_job(1'b0, k, ct_b, q, lat);
    chk("after_reset_data", q, pt_b);
    chk("after_reset_latency", 128'(lat), 128'd49);

    // Back-to-back: start raised during the done cycle
    run_job(1'b0, k, ct_a, q, lat);
    chk("b2b_first_data", q, pt_a);
    set_in(1'b0, 1'b1, k, ct_b);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, k, ct_a);
    wait_done(1'b0, 200, lat);
    chk("b2b_gap", 128'(lat + 1), 128'd50);
    chk("b2b_second_data", if48.data_out, pt_b);

    // Random round trips
    for (int n = 0; n < 200; n++) begin
      k    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt_a = {$urandom, $urandom, $urandom, $urandom};
      run_job(1'b0, k, m_encrypt(k, pt_a, 48), q, lat);
      chk("random_roundtrip", q, pt_a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
